// File: rtl/output_bank_pkg.sv
// Shared types and reset constants for the output bank arbiter.
// Imported by the interface and all arbiter modules.
package output_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam state_t     ST_RST  = IDLE;
  localparam logic       RO_RST  = 1'b0;
  localparam logic [1:0] ROA_RST = 2'b00;

endpackage

// File: rtl/output_bank_arbiter_if.sv
// Request/commit bundle between requesters and the output bank arbiter.
// master drives requests and data; slave is the arbiter.
interface output_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 8
);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ-1:0]         wd_o;
  logic [2*NREQ-1:0]       wd_oa;
  logic [NREQ-1:0]         gnt;
  logic                    ro;
  logic [1:0]              roa;
  logic                    wo;
  logic [1:0]              woa;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;
  logic [CNTW-1:0]         wr_count;

  modport master (
    output req, lock, wd_o, wd_oa,
    input  gnt, ro, roa, wo, woa,
    input  busy, owner, wr_count
  );

  modport slave (
    input  req, lock, wd_o, wd_oa,
    output gnt, ro, roa, wo, woa,
    output busy, owner, wr_count
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner search: first set req bit above last, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int LW = $clog2(NREQ);

  // Scan from the farthest slot down so the nearest one overwrites last.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NREQ]) begin
        winner = LW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/output_bank_arbiter.sv
// Round-robin arbiter committing one requester's data into a shared
// output bank, with optional lock to hold ownership across cycles.
module output_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  output_bank_arbiter_if.slave bus
);

  import output_bank_pkg::*;

  localparam int            LW       = $clog2(NREQ);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [LW-1:0]     owner_q, owner_d;
  logic [LW-1:0]     last_q, last_d;
  logic [LW-1:0]     win;
  logic              any;
  logic              commit;
  logic              own_req;
  logic              own_lock;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              ro_q, ro_d;
  logic [1:0]        roa_q, roa_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (win),
    .any    (any)
  );

  assign own_req  = bus.req[owner_q];
  assign own_lock = bus.lock[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        commit  = own_req;
        state_d = (own_req && own_lock) ? HOLD : IDLE;
      end
      HOLD: begin
        if (!own_lock) state_d = IDLE;
        else           commit  = own_req;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    ro_d   = ro_q;
    roa_d  = roa_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (commit) begin
      gnt_d[owner_q] = 1'b1;
      ro_d           = bus.wd_o[owner_q];
      roa_d          = bus.wd_oa[{owner_q, 1'b0} +: 2];
      last_d         = owner_q;
      cnt_d          = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      last_q  <= LAST_RST;
      gnt_q   <= '0;
      ro_q    <= RO_RST;
      roa_q   <= ROA_RST;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ro_q    <= ro_d;
      roa_q   <= roa_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ro       = ro_q;
  assign bus.roa      = roa_q;
  assign bus.wo       = ro_q;
  assign bus.woa      = roa_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner_q;
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_output_bank_arbiter.sv
// Self-checking bench for output_bank_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_output_bank_arbiter;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  output_bank_arbiter_if #(.NREQ(N), .CNTW(8)) bus ();
  output_bank_arbiter_if #(.NREQ(N), .CNTW(2)) bw ();

  output_bank_arbiter #(.NREQ(N), .CNTW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  output_bank_arbiter #(.NREQ(N), .CNTW(2)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = bank free, 1 = winner chosen, 2 = owner holding.
  int           ph;
  int           mown;
  int           mlast;
  int           mcnt;
  logic         mro;
  logic [1:0]   mroa;
  logic [N-1:0] mgnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    ph    = 0;
    mown  = 0;
    mlast = N - 1;
    mcnt  = 0;
    mro   = 1'b0;
    mroa  = 2'b00;
    mgnt  = '0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic mcommit();
    mgnt       = '0;
    mgnt[mown] = 1'b1;
    mro        = bus.wd_o[mown];
    mroa       = bus.wd_oa[2*mown +: 2];
    mlast      = mown;
    mcnt       = (mcnt + 1) % 256;
  endtask

  task automatic mstep();
    mgnt = '0;
    case (ph)
      0: if (bus.req != '0) begin
        mown = pick(bus.req, mlast);
        ph   = 1;
      end
      1: begin
        if (bus.req[mown]) begin
          mcommit();
          ph = bus.lock[mown] ? 2 : 0;
        end else begin
          ph = 0;
        end
      end
      default: begin
        if (!bus.lock[mown]) ph = 0;
        else if (bus.req[mown]) mcommit();
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(mgnt));
    chk({tag, ".ro"}, 32'(bus.ro), 32'(mro));
    chk({tag, ".roa"}, 32'(bus.roa), 32'(mroa));
    chk({tag, ".wo"}, 32'(bus.wo), 32'(mro));
    chk({tag, ".woa"}, 32'(bus.woa), 32'(mroa));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(ph != 0));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(mown));
    chk({tag, ".cnt"}, 32'(bus.wr_count), 32'(mcnt));
    chk({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic step(input string tag, input logic [N-1:0] r,
                      input logic [N-1:0] l, input logic [N-1:0] d,
                      input logic [2*N-1:0] da);
    bus.req   = r;
    bus.lock  = l;
    bus.wd_o  = d;
    bus.wd_oa = da;
    @(posedge clk);
    mstep();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_ro"}, 32'(bus.ro), 32'd0);
    chk({tag, ".rst_roa"}, 32'(bus.roa), 32'd0);
    chk({tag, ".rst_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".rst_cnt"}, 32'(bus.wr_count), 32'd0);
    chk({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".rst_owner"}, 32'(bus.owner), 32'd0);
    mreset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_w[6];
    logic [N-1:0] r;
    logic [N-1:0] l;

    exp_w = '{0, 1, 2, 3, 0, 1};
    bus.req = '0;  bus.lock = '0;  bus.wd_o = '0;  bus.wd_oa = '0;
    bw.req  = '0;  bw.lock  = '0;  bw.wd_o  = '0;  bw.wd_oa  = '0;
    mreset();

    // Reset asserted between clock edges, before any activity.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst0");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("idle");

    // Counter wrap on the narrow instance: lock requester 0.
    bw.req  = 4'b0001;
    bw.lock = 4'b0001;
    bw.wd_o = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("wrap.cnt", 32'(bw.wr_count), 32'(exp_w[i]));
      chk("wrap.gnt", 32'(bw.gnt), (i == 0) ? 32'd0 : 32'd1);
    end
    bw.req  = '0;
    bw.lock = '0;

    // Single request from requester 2.
    step("single0", 4'b0100, 4'b0000, 4'b0100, 8'b0010_0000);
    chk("single0.gnt_lat", 32'(bus.gnt), 32'd0);
    step("single1", 4'b0100, 4'b0000, 4'b0100, 8'b0010_0000);
    chk("single.gnt", 32'(bus.gnt), 32'b0100);
    chk("single.ro", 32'(bus.ro), 32'd1);
    chk("single.roa", 32'(bus.roa), 32'b10);
    chk("single.wo", 32'(bus.wo), 32'd1);
    chk("single.woa", 32'(bus.woa), 32'b10);
    chk("single.cnt", 32'(bus.wr_count), 32'd1);

    // Fairness from a fresh reset: 0,1,2,3,0.
    async_reset("fair");
    for (int i = 0; i < 10; i++) begin
      step("fair", 4'b1111, 4'b0000, 4'($urandom), 8'($urandom));
      if (i % 2 == 1)
        chk("fair.order", 32'(bus.gnt), 32'(1 << ((i / 2) % N)));
    end

    // Lock: requester 1 holds the bank, then releases to 2.
    for (int i = 0; i < 6; i++) begin
      step("lock", 4'b1111, 4'b0010, 4'($urandom), 8'($urandom));
      if (i >= 1) chk("lock.gnt", 32'(bus.gnt), 32'b0010);
    end
    step("unlock", 4'b1111, 4'b0000, 4'($urandom), 8'($urandom));
    chk("unlock.gnt", 32'(bus.gnt), 32'd0);
    step("next0", 4'b1111, 4'b0000, 4'($urandom), 8'($urandom));
    step("next1", 4'b1111, 4'b0000, 4'($urandom), 8'($urandom));
    chk("next.gnt", 32'(bus.gnt), 32'b0100);

    // Abort: requester 3 drops in its GRANT cycle.
    step("abort0", 4'b1000, 4'b0000, 4'b1111, 8'hff);
    step("abort1", 4'b0000, 4'b0000, 4'b1111, 8'hff);
    chk("abort.gnt", 32'(bus.gnt), 32'd0);
    step("abort2", 4'b1001, 4'b0000, 4'b0000, 8'h00);
    chk("abort.owner", 32'(bus.owner), 32'd3);
    step("abort3", 4'b1001, 4'b0000, 4'b0000, 8'h00);
    chk("abort.regnt", 32'(bus.gnt), 32'b1000);

    // Reset while holding abandons the commit.
    step("hold0", 4'b0001, 4'b0001, 4'b0001, 8'h03);
    step("hold1", 4'b0001, 4'b0001, 4'b0001, 8'h03);
    async_reset("hold");
    step("hold2", 4'b0001, 4'b0001, 4'b0001, 8'h03);
    chk("hold.busy", 32'(bus.busy), 32'd1);

    // Randomized traffic with sporadic asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      if ($urandom_range(3, 0) == 0) r = '1;
      l = 4'($urandom) & 4'($urandom);
      step("rand", r, l, 4'($urandom), 8'($urandom));
      if ($urandom_range(39, 0) == 0) async_reset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_bank_arbiter.md
OUTPUT_BANK_ARBITER -- requirements
Module: output_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter CNTW, default 8, width of the commit counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NREQ  per-requester write request, level.
REQ-006 lock  input  NREQ  per-requester hold-ownership request, sampled only for the current owner.
REQ-007 wd_o  input  NREQ  per-requester scalar write data.
REQ-008 wd_oa  input  2*NREQ  per-requester 2-bit write data; requester i uses bits [2i+1:2i].
REQ-009 gnt  output  NREQ  one-hot commit strobe, high exactly in the cycle its data is written.
REQ-010 ro  output  1  registered scalar bank output.
REQ-011 roa  output  2  registered 2-bit bank output.
REQ-012 wo  output  1  continuous copy of ro; wire, never procedurally assigned.
REQ-013 woa  output  2  continuous copy of roa; wire, never procedurally assigned.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 owner  output  $clog2(NREQ)  index of the current/last owner.
REQ-016 wr_count  output  CNTW  number of commits, wraps modulo 2^CNTW.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, HOLD.
REQ-018 IDLE: if any req bit set, winner = first set bit searching upward from (last+1) mod NREQ, wrapping; register winner into owner; go GRANT. Otherwise stay.
REQ-019 GRANT: if req[owner] still high, pulse gnt[owner], load ro<=wd_o[owner], roa<=wd_oa[owner], last<=owner, wr_count++; then go HOLD if lock[owner] else IDLE.
REQ-020 GRANT with req[owner] dropped: no write, no gnt, last unchanged, go IDLE.
REQ-021 HOLD: each cycle with req[owner] high commits as in REQ-019; stay while lock[owner] high; when lock[owner] low, go IDLE in that cycle with no commit.
REQ-022 Other requesters SHALL NOT be granted while in GRANT or HOLD.
REQ-023 Latency: req rising in IDLE at cycle N gives gnt and updated ro/roa at cycle N+2 edge outputs (visible from N+2).
REQ-024 gnt SHALL be all-zero or one-hot in every cycle.
REQ-025 wr_count at all-ones SHALL wrap to zero on the next commit.
REQ-026 Simultaneous requests with last=NREQ-1 SHALL grant requester 0 first.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, gnt=0, ro=0, roa=0, owner=0, last=NREQ-1, wr_count=0, independent of clk.
REQ-028 Reset asserted mid-GRANT or mid-HOLD SHALL abandon the commit; release SHALL resume in IDLE on the first clk edge after rst_n high.

Structure
REQ-029 State enum (IDLE, GRANT, HOLD) and reset constants SHALL live in shared package output_bank_pkg.
REQ-030 Round-robin selection SHALL be one sub-module rr_pick (inputs req, last; output winner, any).
REQ-031 wo/woa SHALL be produced by continuous assignment from ro/roa only.

Verification
REQ-032 Reset: drive rst_n=0 asynchronously mid-cycle -> ro=0, roa=0, gnt=0, wr_count=0, busy=0 immediately.
REQ-033 Single request: req=4'b0100, wd_o[2]=1, wd_oa=2'b10 -> gnt=4'b0100 two cycles later, ro=1, roa=2'b10, wo=1, woa=2'b10, wr_count=1.
REQ-034 Fairness: req=4'b1111 held with lock=0 -> grants 0,1,2,3,0 in order, one every 2 cycles.
REQ-035 Lock: owner 1 with lock[1]=1 for 5 cycles, req=4'b1111 -> gnt[1] each HOLD cycle, no other gnt, then gnt[2] next after lock[1] drops.
REQ-036 Abort: req[3] dropped in GRANT cycle -> no gnt, ro/roa unchanged, next round still starts from last.
REQ-037 Wrap: CNTW=2, five commits -> wr_count sequence 1,2,3,0,1.
